// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch and data request ports, the single-port memory
// command/response, and the registered results, acks and PC-advance permit.
interface mem_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] instr_out;
  logic [DW-1:0] data_out;
  logic          if_ack;
  logic          dm_ack;
  logic          pc_enable;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we, instr_out, data_out, if_ack, dm_ack,
           pc_enable
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we, instr_out, data_out, if_ack, dm_ack,
           pc_enable
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single-port synchronous memory.
// Each access takes IDLE (grant, command) -> BUSY (capture read data) -> RESP (ack).
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data
// always wins a tie.
module mem_arbiter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q, state_d;
  logic          gnt_data_q, gnt_data_d;   // latched winner: 1 = data side
  logic          gnt_store_q, gnt_store_d; // latched data access is a store
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] data_q, data_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;

  logic          dm_req;
  logic          data_wins;
  logic          grant;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;

  assign dm_req = bus.dm_read | bus.dm_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d; // 1 = data side has priority on the next tie

  assign data_wins = dm_req & (~bus.if_req | ptr_q);

  // Priority pointer moves to the losing side on every grant
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = ~data_wins;
  end

  // Pointer register; reset favours data
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end
`else
  assign data_wins = dm_req;
`endif

  // Grants only happen from IDLE and never while reset is held
  assign grant = (state_q == StIdle) & (dm_req | bus.if_req) & ~rst;

  // Next-state, grant latch, read capture and ack generation
  always_comb begin
    state_d     = state_q;
    gnt_data_d  = gnt_data_q;
    gnt_store_d = gnt_store_q;
    instr_d     = instr_q;
    data_d      = data_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d     = StBusy;
          gnt_data_d  = data_wins;
          gnt_store_d = data_wins & bus.dm_write;
        end
      end
      StBusy: begin
        state_d = StResp;
        if (!gnt_data_q)       instr_d = bus.mem_rdata;
        else if (!gnt_store_q) data_d  = bus.mem_rdata;
        if_ack_d = ~gnt_data_q;
        dm_ack_d = gnt_data_q;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory command is driven only in a granting IDLE cycle
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (grant) begin
      if (data_wins) begin
        mem_addr = bus.dm_addr;
        if (bus.dm_write) begin
          mem_we    = 1'b1;
          mem_wdata = bus.dm_wdata;
        end else begin
          mem_re = 1'b1;
        end
      end else begin
        mem_addr = bus.if_addr;
        mem_re   = 1'b1;
      end
    end
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_data_q  <= 1'b0;
      gnt_store_q <= 1'b0;
      instr_q     <= '0;
      data_q      <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_data_q  <= gnt_data_d;
      gnt_store_q <= gnt_store_d;
      instr_q     <= instr_d;
      data_q      <= data_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.instr_out = instr_q;
  assign bus.data_out  = data_q;
  // Reset asserted during RESP suppresses the pending ack
  assign bus.if_ack    = if_ack_q & ~rst;
  assign bus.dm_ack    = dm_ack_q & ~rst;
  assign bus.pc_enable = ~dm_req & (bus.if_ack | ~bus.if_req);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 5, address width; DW, default 32, data width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 if_req  input  1  instruction fetch request; held until if_ack.
REQ-005 if_addr  input  AW  fetch word address.
REQ-006 dm_read / dm_write  input  1 each  data load / store request; held until dm_ack.
REQ-007 dm_addr  input  AW;  dm_wdata  input  DW  data-side address and store data.
REQ-008 mem_rdata  input  DW  memory read data; valid one cycle after mem_re.
REQ-009 mem_addr  output  AW;  mem_wdata  output  DW;  mem_re, mem_we  output  1  single-port memory command.
REQ-010 instr_out, data_out  output  DW  registered read results.
REQ-011 if_ack, dm_ack  output  1  registered one-cycle completion pulses.
REQ-012 pc_enable  output  1  PC advance permit; low means stall.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, RESP; IDLE->BUSY on grant, BUSY->RESP unconditionally, RESP->IDLE unconditionally.
REQ-014 In IDLE, any request SHALL be granted in the same cycle; mem_* SHALL be driven combinationally that cycle from the winner's address/data.
REQ-015 Data request SHALL be dm_read|dm_write; dm_write with dm_read SHALL be treated as a store.
REQ-016 Store: mem_we=1, mem_re=0, mem_wdata=dm_wdata; load/fetch: mem_re=1, mem_we=0.
REQ-017 Outside a granting IDLE cycle, mem_re=mem_we=0, mem_addr=0, mem_wdata=0.
REQ-018 In BUSY, the arbiter SHALL capture mem_rdata into data_out (load) or instr_out (fetch) at the cycle-end edge; a store SHALL leave data_out unchanged.
REQ-019 Winner's ack SHALL be high exactly during RESP; request at cycle N yields ack and valid data in cycle N+2.
REQ-020 No grant SHALL occur in BUSY or RESP; the earliest next grant is N+3; requesters drop request in the cycle after ack.
REQ-021 Grant latched at IDLE SHALL be held through RESP; request/address changes after grant SHALL be ignored.
REQ-022 pc_enable SHALL equal ~(dm_read|dm_write) & (if_ack | ~if_req).
REQ-023 instr_out/data_out SHALL hold their value until the next matching capture.

Reset
REQ-024 rst high at an edge SHALL set state=IDLE, if_ack=dm_ack=0, instr_out=data_out=0, arbitration pointer to data.
REQ-025 While rst is high, mem_we and mem_re SHALL be 0 regardless of state or requests; no memory write occurs.
REQ-026 rst asserted in BUSY or RESP SHALL abort the access; no ack SHALL be issued for it.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN SHALL select arbitration policy.
REQ-028 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the side not granted last; pointer updates on every grant; after reset, data wins the first tie.
REQ-029 Without it: data SHALL always win ties (fixed priority); no pointer register exists.

Verification
REQ-030 Fetch alone: if_req=1, if_addr=3, mem[3]=0xDEADBEEF at N -> mem_re=1, mem_addr=3 at N; if_ack=1, instr_out=0xDEADBEEF at N+2; pc_enable=1 at N+2 only.
REQ-031 Store then load: dm_write, dm_addr=7, dm_wdata=0x12345678 -> mem_we=1 one cycle, dm_ack at N+2; later dm_read addr 7 -> data_out=0x12345678 two cycles after grant.
REQ-032 Simultaneous if_req and dm_read, default build -> data granted first, dm_ack at N+2, fetch granted at N+3, if_ack at N+5; pc_enable=0 until N+5.
REQ-033 Same stimulus with ARB_ROUND_ROBIN_EN, a data grant done just before -> fetch granted first; two back-to-back ties alternate.
REQ-034 rst=1 in BUSY of a load -> no dm_ack, state IDLE, outputs 0 next cycle; rst=1 during an IDLE store request -> mem_we=0, memory unchanged.
REQ-035 dm_read and dm_write both high, addr 2 -> single store, mem_re=0, data_out unchanged, one dm_ack pulse.
